mem_read_aligner: RTL and testbench
===================================

MEM_READ_ALIGNER -- requirements
Module: mem_read_aligner

Interface
REQ-001 Parameter DATA_W, default 32, meaning memory word width in bits; legal values 32 and 64.
REQ-002 Parameter OFF_W, default $clog2(DATA_W/8), meaning byte-offset width; not overridden.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  a memory read beat is presented.
REQ-006 in_ready  output  1  the block accepts the beat this cycle.
REQ-007 in_data  input  DATA_W  raw memory word, big-endian; byte k is in_data[DATA_W-1-8k -: 8].
REQ-008 in_offset  input  OFF_W  byte address offset within the word.
REQ-009 in_size  input  2  access size: 0 full word, 1 halfword, 2 byte, 3 reserved.
REQ-010 in_zero_ext  input  1  1 zero-extends, 0 sign-extends the extracted field.
REQ-011 out_valid  output  1  result is held on out_data.
REQ-012 out_ready  input  1  the consumer takes the result this cycle.
REQ-013 out_data  output  DATA_W  aligned, right-justified, extended load result.
REQ-014 out_err  output  1  qualified by out_valid; the access was illegal.

Function
REQ-015 A beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready, giving full throughput with one output register.
REQ-017 An aligned or non-crossing access (offset + nbytes <= DATA_W/8) SHALL produce out_valid exactly one cycle after acceptance.
REQ-018 Field = nbytes bytes starting at byte in_offset, most significant byte first; the upper DATA_W-8*nbytes bits are zero or copies of the field MSB according to in_zero_ext.
REQ-019 in_size 3 SHALL produce out_err=1 and out_data=0 after one cycle, with no state change beyond the output register.
REQ-020 FSM states: IDLE, SECOND. A crossing access accepted in IDLE stores the upper bytes (offset..last) and goes to SECOND with no output.
REQ-021 In SECOND, the next accepted beat supplies bytes 0..(remaining-1) as the low-order part; offset, size and zero_ext of that beat are ignored; the merged field is extended, registered, and the FSM returns to IDLE.
REQ-022 In SECOND, in_ready SHALL be 1, because the output register is empty.
REQ-023 While out_valid && !out_ready, out_data, out_err and the FSM SHALL hold.

Reset
REQ-024 When rst is asserted, the block SHALL force state IDLE, out_valid 0, out_data 0, out_err 0 and the stored first-beat bytes 0, independent of clk.
REQ-025 Reset in SECOND SHALL discard the pending half-access, and no result for it SHALL ever appear.

Configuration
REQ-026 Macro MEM_RD_MISALIGN_EN defined: crossing accesses are merged over two beats per REQ-020/021.
REQ-027 Macro MEM_RD_MISALIGN_EN undefined: a crossing access completes in one cycle with out_err=1 and out_data=0; state SECOND and its storage are not synthesised.

Structure
REQ-028 Package mem_rd_pkg SHALL hold the size encoding constants (SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD), the FSM state enum and a function returning nbytes for a size.
REQ-029 Sub-module mem_rd_lane_extract (combinational) SHALL perform byte selection and extension; mem_read_aligner owns the handshake, the FSM and the registers.

Verification (DATA_W=32)
REQ-030 Byte, offset 1, sign-extend, data 0x8899AABB -> one cycle later out_data 0xFFFFFF99, out_err 0.
REQ-031 Half, offset 2, zero-extend, data 0x8899AABB -> out_data 0x0000AABB; the same access sign-extended -> 0xFFFFAABB.
REQ-032 With the macro defined: word, offset 3, beats 0x11223344 then 0x55667788 -> single result 0x44556677 one cycle after the second beat; without the macro -> out_err 1, out_data 0 after the first beat.
REQ-033 Back-pressure: out_ready held 0 for 3 cycles with a pending result -> out_data stable, in_ready 0, then one transfer when out_ready rises.
REQ-034 rst pulsed while in SECOND -> out_valid 0 and state IDLE; next aligned byte access 0x000000AB at offset 3 -> 0xFFFFFFAB.
REQ-035 in_size 3 -> out_err 1 and out_data 0, and the following back-to-back accesses are unaffected.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory read aligner: access size encodings,
// the two-beat merge FSM states and the size-to-byte-count helper.
package mem_rd_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } rdState_e;

  // Number of bytes an access of the given size touches; 0 for the reserved code.
  function automatic int sizeBytes(input logic [1:0] size, input int wordBytes);
    case (size)
      SZ_WORD: return wordBytes;
      SZ_HALF: return 2;
      SZ_BYTE: return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mem_rd_lane_extract.sv
// Combinational byte selector and extender. The window is two memory words
// (big-endian, byte 0 in the top bits); the field is nBytes bytes starting at
// byte offset, right-justified, with the upper bits zero- or sign-filled.
// A single-word access places its word in the upper half of the window; a
// merged two-beat access places the first beat high and the second beat low,
// so a crossing field is simply a contiguous run of window bytes.
module mem_rd_lane_extract #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [2*DATA_W-1:0] window,
  input  logic [OFF_W-1:0]    offset,
  input  logic [OFF_W:0]      nBytes,
  input  logic                zeroExt,
  output logic [DATA_W-1:0]   field
);

  localparam int NB = DATA_W / 8;
  localparam int NW = 2 * NB;

  logic [7:0] winByte [NW];
  logic       fillBit;
  logic [OFF_W:0] selIdx;

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : gByte
      assign winByte[gi] = window[2*DATA_W-1-8*gi -: 8];
    end
  endgenerate

  // The first selected byte is the most significant byte of the field.
  assign fillBit = !zeroExt && winByte[{1'b0, offset}][7];

  // Result byte j counts from the LSB, so it comes from window byte offset+nBytes-1-j.
  always_comb begin
    field  = '0;
    selIdx = '0;
    for (int j = 0; j < NB; j++) begin
      if (j < int'(nBytes)) begin
        selIdx = (OFF_W+1)'(int'(offset) + int'(nBytes) - 1 - j);
        field[8*j +: 8] = winByte[selIdx];
      end else begin
        field[8*j +: 8] = {8{fillBit}};
      end
    end
  end

endmodule

// File: rtl/mem_read_aligner.sv
// Load-data aligner: extracts a byte/halfword/word field from a big-endian
// memory word, right-justifies and extends it, behind a one-deep output
// register with valid/ready handshakes on both sides.
// Build option MEM_RD_MISALIGN_EN: when defined, accesses that cross the word
// boundary are merged over two input beats; when undefined they complete at
// once with out_err set.
module mem_read_aligner
  import mem_rd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_zero_ext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int NB = DATA_W / 8;

  logic              outValidReg;
  logic              outErrReg;
  logic [DATA_W-1:0] outDataReg;

  logic              accept;
  logic [OFF_W:0]    inBytes;
  logic              crossing;

  logic [2*DATA_W-1:0] extWindow;
  logic [OFF_W-1:0]    extOffset;
  logic [OFF_W:0]      extBytes;
  logic                extZero;
  logic [DATA_W-1:0]   extField;

  // The output register is the only buffer, so a beat may enter whenever it
  // is empty or being drained this cycle.
  assign in_ready = !outValidReg || out_ready;
  assign accept   = in_valid && in_ready;
  assign inBytes  = (OFF_W+1)'(sizeBytes(in_size, NB));
  assign crossing = (int'(in_offset) + int'(inBytes)) > NB;

`ifdef MEM_RD_MISALIGN_EN
  rdState_e          stateReg;
  logic [DATA_W-1:0] firstWordReg;
  logic [OFF_W-1:0]  firstOffReg;
  logic [1:0]        firstSizeReg;
  logic              firstZeroReg;

  // In SECOND the stored first beat supplies the high bytes and the incoming
  // beat the low bytes; the incoming beat's own offset/size/extension are unused.
  always_comb begin
    extWindow = {in_data, {DATA_W{1'b0}}};
    extOffset = in_offset;
    extBytes  = inBytes;
    extZero   = in_zero_ext;
    if (stateReg == ST_SECOND) begin
      extWindow = {firstWordReg, in_data};
      extOffset = firstOffReg;
      extBytes  = (OFF_W+1)'(sizeBytes(firstSizeReg, NB));
      extZero   = firstZeroReg;
    end
  end
`else
  assign extWindow = {in_data, {DATA_W{1'b0}}};
  assign extOffset = in_offset;
  assign extBytes  = inBytes;
  assign extZero   = in_zero_ext;
`endif

  mem_rd_lane_extract #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) uExtract (
    .window (extWindow),
    .offset (extOffset),
    .nBytes (extBytes),
    .zeroExt(extZero),
    .field  (extField)
  );

  // Handshake, merge FSM and output register; everything holds while a
  // result is stalled because no beat can be accepted then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValidReg  <= 1'b0;
      outErrReg    <= 1'b0;
      outDataReg   <= '0;
`ifdef MEM_RD_MISALIGN_EN
      stateReg     <= ST_IDLE;
      firstWordReg <= '0;
      firstOffReg  <= '0;
      firstSizeReg <= SZ_WORD;
      firstZeroReg <= 1'b0;
`endif
    end else if (accept) begin
`ifdef MEM_RD_MISALIGN_EN
      if (stateReg == ST_SECOND) begin
        outValidReg  <= 1'b1;
        outErrReg    <= 1'b0;
        outDataReg   <= extField;
        stateReg     <= ST_IDLE;
        firstWordReg <= '0;
      end else
`endif
      if (in_size == SZ_RSVD) begin
        outValidReg <= 1'b1;
        outErrReg   <= 1'b1;
        outDataReg  <= '0;
      end else if (crossing) begin
`ifdef MEM_RD_MISALIGN_EN
        outValidReg  <= 1'b0;
        outErrReg    <= 1'b0;
        stateReg     <= ST_SECOND;
        firstWordReg <= in_data;
        firstOffReg  <= in_offset;
        firstSizeReg <= in_size;
        firstZeroReg <= in_zero_ext;
`else
        outValidReg <= 1'b1;
        outErrReg   <= 1'b1;
        outDataReg  <= '0;
`endif
      end else begin
        outValidReg <= 1'b1;
        outErrReg   <= 1'b0;
        outDataReg  <= extField;
      end
    end else if (out_ready) begin
      outValidReg <= 1'b0;
    end
  end

  assign out_valid = outValidReg;
  assign out_data  = outDataReg;
  assign out_err   = outErrReg;

endmodule

// File: tb/tb_mem_read_aligner.sv
// Self-checking bench for mem_read_aligner (DATA_W=32): directed scenarios
// followed by randomized traffic against a byte-list reference model.
// Honours MEM_RD_MISALIGN_EN the same way the design does.
module tb_mem_read_aligner;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_offset;
  logic [1:0]        in_size;
  logic              in_zero_ext;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int compared;
  int mismatched;

  mem_read_aligner #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_offset  (in_offset),
    .in_size    (in_size),
    .in_zero_ext(in_zero_ext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input int off,
                       input int sz, input bit z, input bit ordy);
    in_valid    = v;
    in_data     = d;
    in_offset   = OFF_W'(off);
    in_size     = 2'(sz);
    in_zero_ext = z;
    out_ready   = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: build the field from a byte list, most significant byte first.
  function automatic logic [DATA_W-1:0] extendBytes(input logic [7:0] b [8], input int n, input bit zext);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(b[i]);
    if (!zext && b[0][7] && n < NB) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[DATA_W-1:0];
  endfunction

  function automatic int sizeToN(input int sz);
    if (sz == 0) return NB;
    if (sz == 1) return 2;
    if (sz == 2) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    drive(0, '0, 0, 0, 0, 1);
    rst = 1'b1;
    #3;
    compared++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: got valid=%b err=%b data=%h ready=%b, want valid=0 err=0 data=0 ready=1",
               out_valid, out_err, out_data, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got valid=%b, want 0", out_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_byte_half();
    drive(1, 32'h8899AABB, 1, 2, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFF99 || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL byte_sext: got valid=%b data=%h err=%b, want 1 ffffff99 0", out_valid, out_data, out_err);
    end
    $display("byte off1 sext: data=%h", out_data);
    drive(1, 32'h8899AABB, 2, 1, 1, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000AABB || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL half_zext: got valid=%b data=%h err=%b, want 1 0000aabb 0", out_valid, out_data, out_err);
    end
    $display("half off2 zext: data=%h", out_data);
    drive(1, 32'h8899AABB, 2, 1, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFAABB || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL half_sext: got valid=%b data=%h err=%b, want 1 ffffaabb 0", out_valid, out_data, out_err);
    end
    $display("half off2 sext: data=%h", out_data);
    drive(0, '0, 0, 0, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_after_half: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_cross();
    drive(1, 32'h11223344, 3, 0, 0, 1);
    step();
`ifdef MEM_RD_MISALIGN_EN
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL cross_first: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    drive(1, 32'h55667788, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 32'h44556677 || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL cross_merge: got valid=%b data=%h err=%b, want 1 44556677 0", out_valid, out_data, out_err);
    end
    $display("word off3 merged: data=%h", out_data);
`else
    compared++;
    if (out_valid !== 1'b1 || out_data !== '0 || out_err !== 1'b1) begin
      mismatched++;
      $display("FAIL cross_err: got valid=%b data=%h err=%b, want 1 0 1", out_valid, out_data, out_err);
    end
    $display("word off3 crossing: err=%b", out_err);
`endif
    drive(0, '0, 0, 0, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL cross_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 32'h5A000000, 0, 2, 1, 0);
    step();
    drive(1, 32'h000000C3, 3, 2, 1, 0);
    for (int c = 0; c < 3; c++) begin
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000005A || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL backpressure_hold%0d: got valid=%b data=%h ready=%b, want 1 0000005a 0",
                 c, out_valid, out_data, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure_release_ready: got %b, want 1", in_ready);
    end
    step();
    compared++;
    if (out_valid !== 1'b1 || out_data !== 32'h000000C3) begin
      mismatched++;
      $display("FAIL backpressure_next: got valid=%b data=%h, want 1 000000c3", out_valid, out_data);
    end
    $display("backpressure: held result then next data=%h", out_data);
    drive(0, '0, 0, 0, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reserved();
    drive(1, 32'hDEADBEEF, 0, 3, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== '0) begin
      mismatched++;
      $display("FAIL rsvd_err: got valid=%b err=%b data=%h, want 1 1 0", out_valid, out_err, out_data);
    end
    $display("reserved size: err=%b", out_err);
    drive(1, 32'h80000000, 0, 2, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'hFFFFFF80) begin
      mismatched++;
      $display("FAIL rsvd_next_byte: got valid=%b err=%b data=%h, want 1 0 ffffff80", out_valid, out_err, out_data);
    end
    drive(1, 32'hCAFEF00D, 0, 0, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'hCAFEF00D) begin
      mismatched++;
      $display("FAIL rsvd_next_word: got valid=%b err=%b data=%h, want 1 0 cafef00d", out_valid, out_err, out_data);
    end
    $display("after reserved: word data=%h", out_data);
  endtask

  task automatic test_reset_in_second();
    drive(1, 32'h11223344, 2, 0, 0, 1);
    step();
`ifdef MEM_RD_MISALIGN_EN
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL second_pending: got valid=%b, want 0", out_valid);
    end
`endif
    drive(0, '0, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_data !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got valid=%b err=%b data=%h, want 0 0 0", out_valid, out_err, out_data);
    end
    #1;
    rst = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_discard: got valid=%b, want 0", out_valid);
    end
    drive(1, 32'h000000AB, 3, 2, 0, 1);
    step();
    compared++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'hFFFFFFAB) begin
      mismatched++;
      $display("FAIL reset_then_byte: got valid=%b err=%b data=%h, want 1 0 ffffffab", out_valid, out_err, out_data);
    end
    $display("reset in second then byte: data=%h", out_data);
    drive(0, '0, 0, 0, 0, 1);
    step();
  endtask

  task automatic test_random();
    bit mValid, mErr, mPend, mFirstZ;
    logic [DATA_W-1:0] mData;
    logic [7:0] mStore [8];
    logic [7:0] cur [8];
    logic [7:0] fb [8];
    int mStoreCnt, mFirstN;
    bit expReady;
    int n, off, sz, r;

    rst = 1'b1;
    drive(0, '0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
    mValid = 0; mErr = 0; mPend = 0; mFirstZ = 0; mData = '0;
    mStoreCnt = 0; mFirstN = 0;
    for (int i = 0; i < 8; i++) begin
      mStore[i] = 8'h00;
      cur[i] = 8'h00;
      fb[i] = 8'h00;
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      compared++;
      if (out_valid !== mValid) begin
        mismatched++;
        $display("FAIL rand_valid cyc%0d: got %b, want %b", cyc, out_valid, mValid);
      end else if (mValid) begin
        compared++;
        if (out_data !== mData || out_err !== mErr) begin
          mismatched++;
          $display("FAIL rand_result cyc%0d: got data=%h err=%b, want data=%h err=%b",
                   cyc, out_data, out_err, mData, mErr);
        end else begin
          $display("rand cyc%0d: result data=%h err=%b", cyc, out_data, out_err);
        end
      end

      r = int'($urandom_range(0, 15));
      sz = (r == 15) ? 3 : (r % 3);
      off = int'($urandom_range(0, NB - 1));
      drive(1'($urandom_range(0, 3) != 0), $urandom, off, sz, 1'($urandom), 1'($urandom_range(0, 3) != 0));
      #1;
      expReady = !mValid || out_ready;
      compared++;
      if (in_ready !== expReady) begin
        mismatched++;
        $display("FAIL rand_ready cyc%0d: got %b, want %b", cyc, in_ready, expReady);
      end

      if (in_valid && expReady) begin
        for (int k = 0; k < NB; k++) cur[k] = 8'(in_data >> (8 * (NB - 1 - k)));
        n = sizeToN(sz);
        if (mPend) begin
          r = mFirstN - mStoreCnt;
          for (int i = 0; i < r; i++) mStore[mStoreCnt + i] = cur[i];
          mData = extendBytes(mStore, mFirstN, mFirstZ);
          mErr = 0; mValid = 1; mPend = 0;
        end else if (n == 0) begin
          mData = '0; mErr = 1; mValid = 1;
        end else if (off + n <= NB) begin
          for (int i = 0; i < n; i++) fb[i] = cur[off + i];
          mData = extendBytes(fb, n, in_zero_ext);
          mErr = 0; mValid = 1;
        end else begin
`ifdef MEM_RD_MISALIGN_EN
          mStoreCnt = NB - off;
          for (int i = 0; i < mStoreCnt; i++) mStore[i] = cur[off + i];
          mFirstN = n; mFirstZ = in_zero_ext; mPend = 1; mValid = 0; mErr = 0;
`else
          mData = '0; mErr = 1; mValid = 1;
`endif
        end
      end else if (out_ready) begin
        mValid = 0;
      end
    end
    drive(0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_byte_half();
    test_cross();
    test_backpressure();
    test_reserved();
    test_reset_in_second();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
